// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue
// Description : Elastic IF/ID instruction buffer. A small circular queue of
//               {pc, instr} entries decouples fetch from decode with a
//               valid/ready handshake. It supports a single-cycle flush for
//               branch/jump redirects. The head is registered, so there is
//               no fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_instr,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_instr,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Storage and queue state
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic not_full;
    logic not_empty;
    logic push;
    logic pop;

    // Handshake qualifiers. Readiness depends only on the stored count, so
    // decode's i_ready never reaches back into fetch combinationally.
    always_comb begin
        not_full  = (count < DEPTH_C);
        not_empty = (count != '0);
        push      = i_valid && not_full && !i_flush;
        pop       = not_empty && i_ready && !i_flush;
    end

    // Entry storage. Reset clears contents. Flush leaves the contents as
    // they are, because the cleared pointers make them unreachable anyway.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= i_pc;
            instr_mem[wr_ptr] <= i_instr;
        end
    end

    // Pointers and occupancy. Reset and flush both return to empty. The
    // pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Head presentation. An empty queue shows a NOP at pc 0 so that the
    // immediate generator sees a harmless zero I-immediate.
    always_comb begin
        o_ready = not_full;
        o_valid = not_empty;
        o_count = count;
        if (not_empty) begin
            o_pc    = pc_mem[rd_ptr];
            o_instr = instr_mem[rd_ptr];
        end else begin
            o_pc    = 32'h0;
            o_instr = NOP_INSTR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_queue
// Description : Directed, table-driven self-checking bench for the IF/ID queue
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid, ready;
    logic [31:0] pc, instr;
    logic        out_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  out_count;

    int tests  = 0;
    int failed = 0;
    bit started = 1'b0;

    fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (valid),
        .o_ready (out_ready),
        .i_pc    (pc),
        .i_instr (instr),
        .o_valid (out_valid),
        .i_ready (ready),
        .o_pc    (out_pc),
        .o_instr (out_instr),
        .o_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ready;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_count;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [31:0] p, input logic [31:0] in,
                                input logic rd, input logic ev, input logic er,
                                input logic [1:0] ec, input logic [31:0] ep,
                                input logic [31:0] ei);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.valid = v;  t.pc = p;  t.instr = in;
        t.ready = rd; t.e_valid = ev; t.e_ready = er; t.e_count = ec;
        t.e_pc = ep;  t.e_instr = ei;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Occupancy must never exceed DEPTH once the design is out of reset
    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (!(out_count <= 2'(DEPTH))) begin
                failed++;
                $display("FAIL count_bound: got %0d expected <= %0d", out_count, DEPTH);
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] p, input logic [31:0] in, input logic rd);
        rst_n = r; flush = f; valid = v; pc = p; instr = in; ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic er,
                             input logic [1:0] ec, input logic [31:0] ep,
                             input logic [31:0] ei);
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".ready"}, 32'(out_ready), 32'(er));
        check({tag, ".count"}, 32'(out_count), 32'(ec));
        check({tag, ".pc"},    out_pc,         ep);
        check({tag, ".instr"}, out_instr,      ei);
    endtask

    initial begin
        // rst flush valid pc instr ready | valid ready count pc instr
        // reset then idle
        vecs[0]  = mk(0,0,0, 32'h0,  32'h0,        0, 0,1,0, 32'h0,  NOP);
        vecs[1]  = mk(0,0,0, 32'h0,  32'h0,        0, 0,1,0, 32'h0,  NOP);
        vecs[2]  = mk(1,0,0, 32'h0,  32'h0,        1, 0,1,0, 32'h0,  NOP);
        // streaming with decode always ready
        vecs[3]  = mk(1,0,1, 32'h00, 32'h00500093, 1, 1,1,1, 32'h00, 32'h00500093);
        vecs[4]  = mk(1,0,1, 32'h04, 32'h00A00113, 1, 1,1,1, 32'h04, 32'h00A00113);
        vecs[5]  = mk(1,0,1, 32'h08, 32'h002081B3, 1, 1,1,1, 32'h08, 32'h002081B3);
        vecs[6]  = mk(1,0,0, 32'h0,  32'h0,        1, 0,1,0, 32'h0,  NOP);
        // backpressure and full: third push held off while full
        vecs[7]  = mk(1,0,1, 32'h20, 32'h11111111, 0, 1,1,1, 32'h20, 32'h11111111);
        vecs[8]  = mk(1,0,1, 32'h24, 32'h22222222, 0, 1,0,2, 32'h20, 32'h11111111);
        vecs[9]  = mk(1,0,1, 32'h28, 32'h33333333, 0, 1,0,2, 32'h20, 32'h11111111);
        vecs[10] = mk(1,0,1, 32'h28, 32'h33333333, 1, 1,1,1, 32'h24, 32'h22222222);
        vecs[11] = mk(1,0,1, 32'h28, 32'h33333333, 0, 1,0,2, 32'h24, 32'h22222222);
        vecs[12] = mk(1,0,0, 32'h0,  32'h0,        1, 1,1,1, 32'h28, 32'h33333333);
        vecs[13] = mk(1,0,0, 32'h0,  32'h0,        1, 0,1,0, 32'h0,  NOP);
        // flush with a concurrent push and pop, then a redirect-target push
        vecs[14] = mk(1,0,1, 32'h10, 32'hAAAA0010, 0, 1,1,1, 32'h10, 32'hAAAA0010);
        vecs[15] = mk(1,0,1, 32'h14, 32'hAAAA0014, 0, 1,0,2, 32'h10, 32'hAAAA0010);
        vecs[16] = mk(1,1,1, 32'h18, 32'hAAAA0018, 1, 0,1,0, 32'h0,  NOP);
        vecs[17] = mk(1,0,1, 32'h40, 32'h44444444, 0, 1,1,1, 32'h40, 32'h44444444);
        vecs[18] = mk(1,0,0, 32'h0,  32'h0,        1, 0,1,0, 32'h0,  NOP);
        // reset with flush while full, then normal push
        vecs[19] = mk(1,0,1, 32'h50, 32'h55550050, 0, 1,1,1, 32'h50, 32'h55550050);
        vecs[20] = mk(1,0,1, 32'h54, 32'h55550054, 0, 1,0,2, 32'h50, 32'h55550050);
        vecs[21] = mk(0,1,1, 32'h58, 32'h55550058, 1, 0,1,0, 32'h0,  NOP);
        vecs[22] = mk(1,0,1, 32'h60, 32'h66666666, 0, 1,1,1, 32'h60, 32'h66666666);
        vecs[23] = mk(1,0,0, 32'h0,  32'h0,        1, 0,1,0, 32'h0,  NOP);

        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0;
        pc = '0; instr = '0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].valid,
                  vecs[i].pc, vecs[i].instr, vecs[i].ready);
            started = 1'b1;
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                      vecs[i].e_count, vecs[i].e_pc, vecs[i].e_instr);
        end

        // Wrap-around: push every cycle with decode ready, so the head follows
        // the push order one cycle behind while both pointers wrap repeatedly.
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 1, 32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 1);
            check($sformatf("wrap%0d.pc", k),    out_pc,    32'h100 + 32'(4 * k));
            check($sformatf("wrap%0d.instr", k), out_instr, 32'hC0DE0000 + 32'(k));
            check($sformatf("wrap%0d.count", k), 32'(out_count), 32'd1);
        end
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        check_all("wrap_drain", 0, 1, 0, 32'h0, NOP);

        // Full-depth wrap: fill, drain one, refill, so the pointers wrap at
        // the full boundary and FIFO order is preserved.
        drive(1, 0, 1, 32'h200, 32'hD0000200, 0);
        drive(1, 0, 1, 32'h204, 32'hD0000204, 0);
        check_all("fill2", 1, 0, 2, 32'h200, 32'hD0000200);
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        check_all("pop1", 1, 1, 1, 32'h204, 32'hD0000204);
        drive(1, 0, 1, 32'h208, 32'hD0000208, 0);
        check_all("refill", 1, 0, 2, 32'h204, 32'hD0000204);
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        check_all("pop2", 1, 1, 1, 32'h208, 32'hD0000208);
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        check_all("pop3", 0, 1, 0, 32'h0, NOP);

        // Flush with no push issued; the same cycle pop must not consume
        drive(1, 0, 1, 32'h300, 32'hE0000300, 0);
        drive(1, 1, 0, 32'h0, 32'h0, 1);
        check_all("flush_only", 0, 1, 0, 32'h0, NOP);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
